// File: rtl/frame_fill_writer.sv
// Frame-buffer SRAM owner: passes scan-out reads through during active video
// and executes rectangle fills, one palette index per clock, during blanking.
module frame_fill_writer #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [9:0]  cmd_y0,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [3:0]  cmd_color,
    input  logic        vga_blank_n,
    input  logic [19:0] rd_addr,
    output logic [3:0]  rd_data,
    output logic [19:0] SRAM_ADDR,
    inout  logic [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t      state, state_nx;
    logic [10:0] x0_q, x_last_q, y_last_q, cx, cy;
    logic [3:0]  color_q;
    logic        wr_strobe;
    logic [19:0] wr_addr;
    logic [3:0]  wr_color;
    logic        accept, zero_size, pix_step, in_bounds, row_end, last_pix;
    logic [19:0] pix_addr;
    logic        unused_dq_hi;

    assign accept    = (state == IDLE) && cmd_valid;
    assign zero_size = (cmd_w == 10'd0) || (cmd_h == 10'd0);
    assign pix_step  = (state == FILL) && !vga_blank_n;
    assign in_bounds = (cx < 11'(H_RES)) && (cy < 11'(V_RES));
    assign row_end   = (cx == x_last_q);
    assign last_pix  = row_end && (cy == y_last_q);
    // y*640 + x as shifts; the row pitch is fixed by the frame-buffer layout
    assign pix_addr  = ({9'd0, cy} << 9) + ({9'd0, cy} << 7) + {9'd0, cx};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_valid) state_nx = zero_size ? DONE : FILL;
            FILL: if (pix_step && last_pix) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state == FILL);
        done      = (state == DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x0_q     <= '0;
            x_last_q <= '0;
            y_last_q <= '0;
            cx       <= '0;
            cy       <= '0;
            color_q  <= '0;
        end else if (accept) begin
            x0_q     <= {1'b0, cmd_x0};
            x_last_q <= {1'b0, cmd_x0} + {1'b0, cmd_w} - 11'd1;
            y_last_q <= {1'b0, cmd_y0} + {1'b0, cmd_h} - 11'd1;
            cx       <= {1'b0, cmd_x0};
            cy       <= {1'b0, cmd_y0};
            color_q  <= cmd_color;
        end else if (pix_step) begin
            if (row_end) begin
                cx <= x0_q;
                cy <= cy + 11'd1;
            end else begin
                cx <= cx + 11'd1;
            end
        end
    end

    // Async clear of the strobe is what releases WE_N the moment reset hits
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_color  <= '0;
        end else begin
            wr_strobe <= pix_step && in_bounds;
            if (pix_step && in_bounds) begin
                wr_addr  <= pix_addr;
                wr_color <= color_q;
            end
        end
    end

    assign SRAM_ADDR    = wr_strobe ? wr_addr : rd_addr;
    assign SRAM_DQ      = wr_strobe ? {12'h000, wr_color} : 16'hzzzz;
    assign SRAM_WE_N    = ~wr_strobe;
    assign SRAM_OE_N    = wr_strobe;
    assign SRAM_CE_N    = 1'b0;
    assign SRAM_UB_N    = 1'b0;
    assign SRAM_LB_N    = 1'b0;
    assign rd_data      = wr_strobe ? 4'h0 : SRAM_DQ[3:0];
    assign unused_dq_hi = ^SRAM_DQ[15:4];

endmodule

// File: tb/tb_frame_fill_writer.sv
// Directed and randomized fills checked against a per-pixel rectangle model
// and a simple SRAM model that serves reads from captured writes.
module tb_frame_fill_writer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [3:0]  cmd_color;
    logic        vga_blank_n;
    logic [19:0] rd_addr;
    logic [3:0]  rd_data;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
    logic        busy, done;

    logic [15:0] rd_word;
    logic [15:0] sram [0:307199];
    int unsigned compared = 0;
    int unsigned mismatched = 0;

    frame_fill_writer #(.H_RES(640), .V_RES(480)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .vga_blank_n(vga_blank_n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .busy(busy), .done(done)
    );

    // SRAM drives the bus only for a read cycle
    assign SRAM_DQ = (SRAM_WE_N && !SRAM_OE_N) ? rd_word : 16'hzzzz;

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input int unsigned addr, input logic [3:0] exp);
        rd_addr = 20'(addr);
        rd_word = sram[addr];
        #1;
        chk({tag, "_addr"}, {12'd0, SRAM_ADDR}, addr);
        chk({tag, "_data"}, {28'd0, rd_data}, {28'd0, exp});
    endtask

    // mode: 0 = always blanking, 1 = fixed stall pattern, 2 = random stalls
    task automatic run_cmd(input string tag, input int x0, input int y0, input int w,
                           input int h, input logic [3:0] col, input int mode,
                           input int abort_after);
        int unsigned exp_q[$];
        int unsigned got_q[$];
        int          pat[6] = '{0, 1, 1, 0, 0, 0};
        int          issued = 0;
        int          k = 0;
        bit          seen_done = 0;
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                if (xx < 640 && yy < 480) exp_q.push_back(int'(yy * 640 + xx));

        @(negedge Clk);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 1);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_w = 10'(w); cmd_h = 10'(h);
        cmd_color = col; cmd_valid = 1'b1; vga_blank_n = 1'b1;
        @(negedge Clk);
        cmd_valid = 1'b0;
        cmd_color = ~col;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!SRAM_WE_N) begin
                got_q.push_back(int'(SRAM_ADDR));
                sram[SRAM_ADDR] = SRAM_DQ;
                chk({tag, "_wdata"}, {16'd0, SRAM_DQ}, {28'd0, col});
                chk({tag, "_oe_wr"}, {31'd0, SRAM_OE_N}, 1);
                chk({tag, "_rd_blk"}, {28'd0, rd_data}, 0);
                if (abort_after != 0 && got_q.size() == abort_after) begin
                    Reset_n = 1'b0;
                    #1;
                    chk({tag, "_abort_we"}, {31'd0, SRAM_WE_N}, 1);
                    chk({tag, "_abort_busy"}, {31'd0, busy}, 0);
                    chk({tag, "_abort_oe"}, {31'd0, SRAM_OE_N}, 0);
                    for (int i = 0; i < abort_after; i++)
                        chk($sformatf("%s_addr%0d", tag, i), got_q[i], exp_q[i]);
                    @(negedge Clk);
                    Reset_n = 1'b1;
                    return;
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
                break;
            end
            chk({tag, "_busy"}, {31'd0, busy}, 1);
            case (mode)
                1:       vga_blank_n = pat[k % 6][0];
                2:       vga_blank_n = ($urandom_range(0, 3) == 0);
                default: vga_blank_n = 1'b0;
            endcase
            if (!vga_blank_n) issued++;
            k++;
            @(negedge Clk);
        end
        chk({tag, "_done_seen"}, {31'd0, seen_done}, 1);
        chk({tag, "_steps"}, issued, w * h);
        vga_blank_n = 1'b1;
        @(negedge Clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
        chk({tag, "_ready_back"}, {31'd0, cmd_ready}, 1);
        chk({tag, "_we_idle"}, {31'd0, SRAM_WE_N}, 1);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), got_q[i], exp_q[i]);
        if (exp_q.size() > 0)
            read_check({tag, "_rb"}, exp_q[exp_q.size() - 1], col);
    endtask

    initial begin
        Reset_n = 1'b0; cmd_valid = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0;
        cmd_h = '0; cmd_color = '0; vga_blank_n = 1'b1; rd_addr = 20'd1234;
        for (int i = 0; i < 307200; i++) sram[i] = 16'(i * 7);
        sram[1234] = 16'h0007;
        rd_word = sram[1234];
        #3;
        chk("rst_we", {31'd0, SRAM_WE_N}, 1);
        chk("rst_oe", {31'd0, SRAM_OE_N}, 0);
        chk("rst_ce_ub_lb", {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        read_check("rd_pass", 1234, 4'h7);
        chk("rd_we", {31'd0, SRAM_WE_N}, 1);
        chk("rd_oe", {31'd0, SRAM_OE_N}, 0);

        run_cmd("basic", 10, 20, 2, 2, 4'h5, 0, 0);
        run_cmd("stall", 10, 20, 2, 2, 4'h9, 1, 0);
        run_cmd("clip",  638, 479, 4, 2, 4'h3, 0, 0);
        run_cmd("zero",  5, 5, 0, 5, 4'hA, 0, 0);
        run_cmd("zeroh", 5, 5, 3, 0, 4'hB, 0, 0);
        run_cmd("abort", 50, 60, 2, 2, 4'hC, 0, 3);
        run_cmd("after", 100, 200, 3, 1, 4'hD, 0, 0);
        for (int n = 0; n < 8; n++)
            run_cmd($sformatf("rnd%0d", n),
                    int'($urandom_range(0, 645)), int'($urandom_range(0, 485)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    4'($urandom_range(0, 15)), 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
